// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared owner/state encodings and controller constants
package mem_port_arbiter_pkg;

    // Which requester owns the command currently in flight
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Controller sequencing: arbitrate, strobe the RAM, collect read data
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_e;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    // Bits needed to count 0..limit inclusive (at least one bit)
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of debug arbitration losses
module starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; the count parks at LIMIT until debug is granted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT_V)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_sat = (r_cnt == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-port RAM arbiter with debug anti-starvation
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              sysClk,
    input  logic              sysReset,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWdata,
    output logic              cpuGnt,
    output logic              cpuRvalid,
    output logic [DATA_W-1:0] cpuRdata,
    output logic              cpuStall,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgWdata,
    output logic              dbgGnt,
    output logic              dbgRvalid,
    output logic [DATA_W-1:0] dbgRdata,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    state_e            r_state;
    state_e            w_state_nxt;
    owner_e            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic w_sat;
    logic w_cpu_gnt;
    logic w_dbg_gnt;
    logic w_starve_inc;
    logic w_mem_read;
    logic w_mem_write;
    logic w_cpu_rvalid;
    logic w_dbg_rvalid;
    logic w_cpu_rd_busy;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk (sysClk),
        .i_rst (sysReset),
        .i_inc (w_starve_inc),
        .i_clr (w_dbg_gnt),
        .o_sat (w_sat)
    );

    // FSM state register
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, strobes and next state; everything is held quiet while reset is high
    always_comb begin
        w_state_nxt  = r_state;
        w_cpu_gnt    = 1'b0;
        w_dbg_gnt    = 1'b0;
        w_starve_inc = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_cpu_rvalid = 1'b0;
        w_dbg_rvalid = 1'b0;
        if (!sysReset) begin
            case (r_state)
                ST_IDLE: begin
                    w_dbg_gnt    = dbgReq && (w_sat || !cpuReq);
                    w_cpu_gnt    = cpuReq && !w_dbg_gnt;
                    w_starve_inc = dbgReq && !w_dbg_gnt;
                    if (cpuReq || dbgReq) begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    w_mem_write = r_we;
                    w_mem_read  = !r_we;
                    w_state_nxt = r_we ? ST_IDLE : ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    w_cpu_rvalid = (r_owner == OWN_CPU);
                    w_dbg_rvalid = (r_owner == OWN_DBG);
                    w_state_nxt  = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Command capture on grant and read-data capture on the return cycle
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (w_cpu_gnt) begin
                r_owner <= OWN_CPU;
                r_we    <= cpuWe;
                r_addr  <= cpuAddr;
                r_wdata <= cpuWdata;
            end else if (w_dbg_gnt) begin
                r_owner <= OWN_DBG;
                r_we    <= dbgWe;
                r_addr  <= dbgAddr;
                r_wdata <= dbgWdata;
            end
            if (w_cpu_rvalid) begin
                r_cpu_rdata <= memRdata;
            end
            if (w_dbg_rvalid) begin
                r_dbg_rdata <= memRdata;
            end
        end
    end

    // A CPU read keeps the CPU stalled from its grant through the strobe cycle
    assign w_cpu_rd_busy = (w_cpu_gnt && !cpuWe) ||
                           ((r_state == ST_ISSUE) && (r_owner == OWN_CPU) && !r_we);

    assign cpuGnt    = w_cpu_gnt;
    assign dbgGnt    = w_dbg_gnt;
    assign cpuRvalid = w_cpu_rvalid;
    assign dbgRvalid = w_dbg_rvalid;
    assign cpuStall  = !sysReset && ((cpuReq && !w_cpu_gnt) || w_cpu_rd_busy);
    assign memRead   = w_mem_read;
    assign memWrite  = w_mem_write;
    assign memAddr   = r_addr;
    assign memWdata  = r_wdata;

    // Read data is forwarded in the Rvalid cycle and held from the register afterwards
    assign cpuRdata = w_cpu_rvalid ? memRdata : r_cpu_rdata;
    assign dbgRdata = w_dbg_rvalid ? memRdata : r_dbg_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, number of cycles a pending debug request may lose arbitration before it is forced to win.
REQ-004 SHALL have port sysClk, input, 1, the only clock; all logic is rising-edge.
REQ-005 SHALL have port sysReset, input, 1, synchronous active-high reset.
REQ-006 SHALL have CPU requester ports: cpuReq in 1; cpuWe in 1; cpuAddr in ADDR_W; cpuWdata in DATA_W; cpuGnt out 1; cpuRvalid out 1; cpuRdata out DATA_W; cpuStall out 1.
REQ-007 SHALL have debug/loader requester ports: dbgReq in 1; dbgWe in 1; dbgAddr in ADDR_W; dbgWdata in DATA_W; dbgGnt out 1; dbgRvalid out 1; dbgRdata out DATA_W.
REQ-008 SHALL have RAM-side ports: memRead out 1; memWrite out 1; memAddr out ADDR_W; memWdata out DATA_W; memRdata in DATA_W, valid on the cycle after memRead.

Function
REQ-009 SHALL use FSM states IDLE, ISSUE, RDWAIT; the owner is recorded as CPU or DBG.
REQ-010 In IDLE with one or more requests pending, SHALL pulse the winner's Gnt for 1 cycle, register its We/Addr/Wdata and owner, and go to ISSUE.
REQ-011 Arbitration: CPU wins over debug, unless starveCnt == STARVE_LIMIT, in which case debug wins.
REQ-012 starveCnt: increments (saturating at STARVE_LIMIT) on each IDLE-arbitration cycle where dbgReq=1 and dbgGnt=0; clears to 0 on dbgGnt.
REQ-013 In ISSUE, SHALL drive memAddr/memWdata from the registered command and assert exactly one of memWrite or memRead for exactly 1 cycle.
REQ-014 From ISSUE, a write SHALL go to IDLE; a read SHALL go to RDWAIT.
REQ-015 In RDWAIT, SHALL capture memRdata into the owner's Rdata register, assert the owner's Rvalid for exactly 1 cycle, and go to IDLE.
REQ-016 Latency from Gnt: write 1 cycle to memWrite; read 2 cycles to Rvalid. A new grant is possible on the cycle after returning to IDLE.
REQ-017 Requesters SHALL hold Req and fields stable until Gnt; the arbiter samples fields only in the Gnt cycle. Deasserting Req before Gnt withdraws the request with no side effect.
REQ-018 cpuRdata/dbgRdata SHALL hold the last captured value until the next read by the same owner.
REQ-019 cpuStall SHALL equal cpuReq & ~cpuGnt, or, when a CPU read is outstanding, remain high until the cycle cpuRvalid asserts.
REQ-020 memRead and memWrite SHALL never be high together, and SHALL be low outside ISSUE; memAddr/memWdata hold their last values when idle.
REQ-021 Simultaneous cpuReq and dbgReq at starveCnt == STARVE_LIMIT: debug granted; CPU stalls and wins the next IDLE cycle if debug is not starved again.
REQ-022 Gnt and Rvalid SHALL never assert to both requesters in the same cycle.

Reset
REQ-023 While sysReset=1 at a clock edge: state=IDLE, starveCnt=0, all Gnt/Rvalid/memRead/memWrite/cpuStall=0, memAddr/memWdata/Rdata registers=0.
REQ-024 Reset mid-transaction (ISSUE or RDWAIT) SHALL abort it: no Rvalid is produced and no mem strobe follows reset release.

Structure
REQ-025 Owner encoding (CPU=0, DBG=1) and FSM state encoding SHALL live in the shared CPU package alongside the controller constants.
REQ-026 The starvation counter SHALL be one sub-module, starve_counter (inc, clr, sat flag); the FSM and muxing are in the top module.

Verification
REQ-027 CPU write addr 0x10 data 0xDEADBEEF, debug idle -> cpuGnt at t, memWrite=1/memAddr=0x10 at t+1, IDLE at t+2.
REQ-028 CPU read addr 0x20, RAM holds 0x12345678 -> memRead at t+1, cpuRvalid=1 with cpuRdata=0x12345678 at t+2, cpuStall high t..t+1.
REQ-029 cpuReq and dbgReq continuous, STARVE_LIMIT=4 -> debug granted after 4 lost arbitrations, starveCnt=0 next cycle, CPU wins the following arbitration.
REQ-030 dbgReq raised then dropped before grant while CPU busy -> no dbgGnt, no debug access, starveCnt reaches 0 only on a later grant.
REQ-031 sysReset asserted during RDWAIT of a debug read -> dbgRvalid never asserts, all outputs 0 the cycle after reset, state IDLE.
REQ-032 Random interleaved traffic for 10k cycles -> scoreboard matches RAM model, memRead&memWrite never both 1, no requester waits longer than STARVE_LIMIT+1 arbitrations.
